// File: rtl/prog_load_controller.sv
// Program loader: parses framed bytes from the Bluetooth UART and writes
// big-endian 16-bit words into CPU instruction memory, holding the CPU in
// reset while a frame is in flight.
//
// Frame: SYNC_BYTE, LEN (1..255), LEN x {hi, lo}, CSUM (XOR of LEN and data).
//
// Ports:
//   clk         system clock
//   pc_reset_n  asynchronous active-low reset
//   rx_valid    one-cycle strobe, rx_byte valid
//   rx_byte     received byte
//   prog_addr   instruction-memory write address
//   prog_data   instruction-memory write data
//   prog_ld     one-cycle write strobe
//   cpu_hold    high = CPU held in reset
//   load_done   sticky, last frame loaded with good checksum
//   load_error  sticky, last frame aborted
//   word_count  words written in current/last frame
module prog_load_controller #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        pc_reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [15:0] prog_addr,
  output logic [15:0] prog_data,
  output logic        prog_ld,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  word_count
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t              state, state_next;
  logic [BYTE_W-1:0]   len, len_next;
  logic [BYTE_W-1:0]   hi, hi_next;
  logic [BYTE_W-1:0]   csum, csum_next;
  logic [ADDR_W-1:0]   idle_cnt, idle_cnt_next;
  logic [ADDR_W-1:0]   prog_addr_next, prog_data_next;
  logic                prog_ld_next, cpu_hold_next;
  logic                load_done_next, load_error_next;
  logic [BYTE_W-1:0]   word_count_next;

  logic                timed_c;
  logic                start_c;
  logic                timeout_c;
  logic                last_word_c;

  // States in which the inter-byte watchdog runs.
  assign timed_c = (state == S_LEN) || (state == S_HI) ||
                   (state == S_LO)  || (state == S_CSUM);

  // A sync byte opens a new frame only when no frame is in progress.
  assign start_c = rx_valid && (rx_byte == SYNC_BYTE) &&
                   ((state == S_IDLE) || (state == S_ERR));

  assign timeout_c = timed_c && !rx_valid &&
                     (ADDR_W'(idle_cnt + 16'd1) == TIMEOUT_CYCLES);

  // 9-bit compare so a full 255-word frame cannot wrap.
  assign last_word_c = (({1'b0, word_count} + 9'd1) == {1'b0, len});

  // State and datapath registers.
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state      <= S_IDLE;
      len        <= '0;
      hi         <= '0;
      csum       <= '0;
      idle_cnt   <= '0;
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_ld    <= 1'b0;
      cpu_hold   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_next;
      len        <= len_next;
      hi         <= hi_next;
      csum       <= csum_next;
      idle_cnt   <= idle_cnt_next;
      prog_addr  <= prog_addr_next;
      prog_data  <= prog_data_next;
      prog_ld    <= prog_ld_next;
      cpu_hold   <= cpu_hold_next;
      load_done  <= load_done_next;
      load_error <= load_error_next;
      word_count <= word_count_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start_c) state_next = S_LEN;
      S_LEN:   if (rx_valid) state_next = (rx_byte == 8'h00) ? S_ERR : S_HI;
      S_HI:    if (rx_valid) state_next = S_LO;
      S_LO:    if (rx_valid) state_next = S_WRITE;
      S_WRITE: begin
        // A byte arriving during the write slot is an overrun and is dropped.
        if (rx_valid)         state_next = S_ERR;
        else if (last_word_c) state_next = S_CSUM;
        else                  state_next = S_HI;
      end
      S_CSUM:  if (rx_valid) state_next = (rx_byte == csum) ? S_DONE : S_ERR;
      S_DONE:  state_next = S_IDLE;
      S_ERR:   if (start_c) state_next = S_LEN;
      default: state_next = S_IDLE;
    endcase
    if (timeout_c) state_next = S_ERR;
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    len_next        = len;
    hi_next         = hi;
    csum_next       = csum;
    prog_addr_next  = prog_addr;
    prog_data_next  = prog_data;
    cpu_hold_next   = cpu_hold;
    load_done_next  = load_done;
    load_error_next = load_error;
    word_count_next = word_count;

    // Strobe is registered so it is high exactly while in WRITE.
    prog_ld_next = (state_next == S_WRITE);

    // Watchdog counts silent cycles only while waiting on frame bytes.
    if (rx_valid || !timed_c || (state_next != state && !(
        (state_next == S_LEN) || (state_next == S_HI) ||
        (state_next == S_LO)  || (state_next == S_CSUM))))
      idle_cnt_next = '0;
    else
      idle_cnt_next = ADDR_W'(idle_cnt + 16'd1);

    if (start_c) begin
      cpu_hold_next   = 1'b1;
      load_done_next  = 1'b0;
      load_error_next = 1'b0;
      word_count_next = '0;
      csum_next       = '0;
    end

    unique case (state)
      S_LEN: if (rx_valid && rx_byte != 8'h00) begin
        len_next  = rx_byte;
        csum_next = csum ^ rx_byte;
      end
      S_HI: if (rx_valid) begin
        hi_next   = rx_byte;
        csum_next = csum ^ rx_byte;
      end
      S_LO: if (rx_valid) begin
        prog_data_next = {hi, rx_byte};
        prog_addr_next = ADDR_W'(BASE_ADDR + {8'h00, word_count});
        csum_next      = csum ^ rx_byte;
      end
      S_WRITE: word_count_next = BYTE_W'(word_count + 8'd1);
      default: ;
    endcase

    if (state_next == S_DONE) begin
      load_done_next = 1'b1;
      cpu_hold_next  = 1'b0;
    end
    if (state_next == S_ERR && state != S_ERR)
      load_error_next = 1'b1;
  end

endmodule

// File: tb/tb_prog_load_controller.sv
// Directed bench for prog_load_controller with a short watchdog timeout.
module tb_prog_load_controller;

  localparam logic [15:0] TOUT = 16'd16;

  logic        clk;
  logic        pc_reset_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [15:0] prog_addr;
  logic [15:0] prog_data;
  logic        prog_ld;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [7:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Write monitor: every cycle with prog_ld high is one captured write.
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          ld_cnt  = 0;
  int          ld_long = 0;
  logic        ld_prev = 1'b0;
  int          base;

  prog_load_controller #(
    .BASE_ADDR(16'h0000), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .pc_reset_n(pc_reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_ld(prog_ld),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog_ld) begin
      wr_addr.push_back(prog_addr);
      wr_data.push_back(prog_data);
      ld_cnt = ld_cnt + 1;
      if (ld_prev) ld_long = ld_long + 1;
    end
    ld_prev = prog_ld;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe, then one idle cycle; returns 1ns after a posedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_good;
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h42);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pc_reset_n = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    #23;
    check("rst_addr", 32'(prog_addr), 32'h0);
    check("rst_data", 32'(prog_data), 32'h0);
    check("rst_ld",   32'(prog_ld),   32'h0);
    check("rst_hold", 32'(cpu_hold),  32'h0);
    check("rst_done", 32'(load_done), 32'h0);
    check("rst_err",  32'(load_error), 32'h0);
    check("rst_wc",   32'(word_count), 32'h0);
    pc_reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Noise in IDLE
    base = ld_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("noise_hold", 32'(cpu_hold), 32'h0);
    check("noise_err",  32'(load_error), 32'h0);
    check("noise_wr",   32'(ld_cnt - base), 32'h0);

    // Good frame
    base = ld_cnt;
    check("good_hold_pre", 32'(cpu_hold), 32'h0);
    send_byte(8'hA5);
    check("good_hold_sync", 32'(cpu_hold), 32'h1);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    check("good_hold_mid", 32'(cpu_hold), 32'h1);
    send_byte(8'h42);
    check("good_wr", 32'(ld_cnt - base), 32'h2);
    if (ld_cnt - base == 2) begin
      check("good_a0", 32'(wr_addr[base]),   32'h0000);
      check("good_d0", 32'(wr_data[base]),   32'h1234);
      check("good_a1", 32'(wr_addr[base+1]), 32'h0001);
      check("good_d1", 32'(wr_data[base+1]), 32'hABCD);
    end
    check("good_wc",   32'(word_count), 32'h2);
    check("good_done", 32'(load_done),  32'h1);
    check("good_err",  32'(load_error), 32'h0);
    check("good_hold", 32'(cpu_hold),   32'h0);
    check("good_pulse", 32'(ld_long),   32'h0);

    // Bad checksum, then resend good frame
    base = ld_cnt;
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h43);
    check("bad_wr",   32'(ld_cnt - base), 32'h2);
    check("bad_err",  32'(load_error), 32'h1);
    check("bad_done", 32'(load_done),  32'h0);
    check("bad_hold", 32'(cpu_hold),   32'h1);
    send_good();
    check("resend_done", 32'(load_done), 32'h1);
    check("resend_err",  32'(load_error), 32'h0);
    check("resend_hold", 32'(cpu_hold), 32'h0);

    // Zero length
    base = ld_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    check("zero_err",  32'(load_error), 32'h1);
    check("zero_wr",   32'(ld_cnt - base), 32'h0);
    check("zero_hold", 32'(cpu_hold), 32'h1);
    check("zero_wc",   32'(word_count), 32'h0);

    // Timeout after hi byte
    base = ld_cnt;
    send_byte(8'hA5);
    check("to_err_clr", 32'(load_error), 32'h0);
    send_byte(8'h02);
    send_byte(8'h12);
    repeat (14) @(posedge clk);
    #1 check("to_early", 32'(load_error), 32'h0);
    @(posedge clk);
    #1 check("to_fire", 32'(load_error), 32'h1);
    check("to_wr",   32'(ld_cnt - base), 32'h0);
    check("to_hold", 32'(cpu_hold), 32'h1);

    // Overrun: strobe in the WRITE cycle
    base = ld_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h34;
    @(posedge clk);
    @(negedge clk);
    rx_byte  = 8'h77;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ovr_wr", 32'(ld_cnt - base), 32'h1);
    if (ld_cnt - base == 1)
      check("ovr_d0", 32'(wr_data[base]), 32'h1234);
    check("ovr_err",  32'(load_error), 32'h1);
    check("ovr_hold", 32'(cpu_hold), 32'h1);

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    #2 pc_reset_n = 1'b0;
    #1;
    check("mrst_data", 32'(prog_data), 32'h0);
    check("mrst_hold", 32'(cpu_hold), 32'h0);
    check("mrst_wc",   32'(word_count), 32'h0);
    check("mrst_err",  32'(load_error), 32'h0);
    check("mrst_ld",   32'(prog_ld), 32'h0);
    #10 pc_reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    base = ld_cnt;
    send_good();
    check("post_wr",   32'(ld_cnt - base), 32'h2);
    check("post_done", 32'(load_done), 32'h1);
    check("post_hold", 32'(cpu_hold), 32'h0);
    check("post_wc",   32'(word_count), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
